wb_intercon: RTL



---
 rtl/wb_pkg.sv | 8 +
 rtl/wb_timeout_cnt.sv | 19 +
 rtl/wb_intercon.sv | 106 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared state encoding, error causes and bus widths for wb_intercon
package wb_pkg;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] ERR_DECODE  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    typedef enum logic [1:0] {IDLE, BUSY, DECERR, TOERR} state_t;
endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: counts unanswered BUSY cycles and flags the last allowed one
module wb_timeout_cnt #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt;
    // restart on each accepted transfer, advance while the slave stays silent
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (run) cnt <= cnt + 1'b1;
    assign expired = cnt == CW'(TIMEOUT - 1);
endmodule

// File: rtl/wb_intercon.sv
// wb_intercon: single-master Wishbone classic decoder/router; WB_INTERCON_TIMEOUT_EN adds hung-slave timeout
module wb_intercon
    import wb_pkg::*;
#(
    parameter int                    N_SLAVES   = 5,
    parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = {N_SLAVES{32'h0}},
    parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = {N_SLAVES{32'hFFFFFF00}},
    parameter int                    TIMEOUT    = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   m_cyc,
    input  logic                   m_stb,
    input  logic [AW-1:0]          m_adr,
    output logic                   m_ack,
    output logic                   m_err,
    output logic                   m_rty,
    output logic [DW-1:0]          m_dat,
    output logic [N_SLAVES-1:0]    s_stb,
    input  logic [N_SLAVES-1:0]    s_ack,
    input  logic [N_SLAVES-1:0]    s_err,
    input  logic [N_SLAVES-1:0]    s_rty,
    input  logic [N_SLAVES*DW-1:0] s_dat,
    output logic                   err_valid,
    output logic [AW-1:0]          err_addr,
    output logic [1:0]             err_cause,
    input  logic                   err_clr
);
    localparam int SW = N_SLAVES > 1 ? $clog2(N_SLAVES) : 1;
    state_t state, state_nxt;
    logic [SW-1:0] sel, hit_idx;
    logic hit, resp, expired, accept, err_entry;
    // address decode; scanning downwards lets the lowest matching slot win
    always_comb begin
        hit = 1'b0;
        hit_idx = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--)
            if ((m_adr & SLAVE_MASK[32*k +: 32]) == SLAVE_BASE[32*k +: 32]) begin
                hit = 1'b1;
                hit_idx = SW'(k);
            end
    end
    assign resp      = s_ack[sel] | s_err[sel] | s_rty[sel];
    assign accept    = state == IDLE && m_cyc && m_stb && hit;
    assign err_entry = state_nxt == DECERR || state_nxt == TOERR;
    // next state and master/slave routing; only the latched slot is visible
    always_comb begin
        state_nxt = state;
        s_stb = '0;
        m_ack = 1'b0;
        m_err = 1'b0;
        m_rty = 1'b0;
        m_dat = '0;
        case (state)
            IDLE: if (m_cyc && m_stb) state_nxt = hit ? BUSY : DECERR;
            BUSY: begin
                s_stb[sel] = m_cyc & m_stb;
                m_ack = s_ack[sel];
                m_err = s_err[sel];
                m_rty = s_rty[sel];
                m_dat = s_dat[DW*sel +: DW];
                if (resp || !m_cyc) state_nxt = IDLE;
                else if (expired) state_nxt = TOERR;
            end
            default: begin
                m_err = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end
    // state register; the selection is held for the whole transfer
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            sel <= '0;
        end else begin
            state <= state_nxt;
            if (accept) sel <= hit_idx;
        end
    // keep the first unacknowledged error; a clear in the same cycle admits the new one
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            err_valid <= 1'b0;
            err_addr <= '0;
            err_cause <= '0;
        end else begin
            if (err_entry && (!err_valid || err_clr)) begin
                err_addr <= m_adr;
                err_cause <= state_nxt == TOERR ? ERR_TIMEOUT : ERR_DECODE;
            end
            err_valid <= err_entry | (err_valid & ~err_clr);
        end
`ifdef WB_INTERCON_TIMEOUT_EN
    wb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_to (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .run     (state == BUSY && !resp),
        .expired (expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign expired = 1'b0;
`endif
endmodule
